// File: rtl/dice_display_pkg.sv
// Shared constants for the dice seven-segment display: active-low segment
// patterns, the internal symbol codes and the digit positions.
package dice_display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_r     = 7'h2F;
    localparam logic [6:0] SEG_o     = 7'h23;

    // Symbol codes; 'S' reuses SYM_5 and capital 'O' reuses SYM_0
    typedef enum logic [3:0] {
        SYM_0     = 4'd0,
        SYM_1     = 4'd1,
        SYM_2     = 4'd2,
        SYM_3     = 4'd3,
        SYM_4     = 4'd4,
        SYM_5     = 4'd5,
        SYM_6     = 4'd6,
        SYM_DASH  = 4'd7,
        SYM_BLANK = 4'd8,
        SYM_P     = 4'd9,
        SYM_A     = 4'd10,
        SYM_L     = 4'd11,
        SYM_E     = 4'd12,
        SYM_r     = 4'd13,
        SYM_o     = 4'd14
    } sym_e;

    // Digit positions (0 = rightmost)
    localparam logic [2:0] DIG_DICE2 = 3'd0;
    localparam logic [2:0] DIG_DICE1 = 3'd1;
    localparam logic [2:0] DIG_LAST  = 3'd7;

    // Die value -> symbol: 0 means "not rolled yet", 7 is not a legal face
    function automatic sym_e die_sym(input logic [2:0] v);
        case (v)
            3'd0:    return SYM_DASH;
            3'd1:    return SYM_1;
            3'd2:    return SYM_2;
            3'd3:    return SYM_3;
            3'd4:    return SYM_4;
            3'd5:    return SYM_5;
            3'd6:    return SYM_6;
            default: return SYM_BLANK;
        endcase
    endfunction

    // Status word letter; pos 0 is the leftmost digit. Win beats Lose beats Roll.
    function automatic sym_e status_sym(input logic w, input logic l,
                                        input logic r, input logic [1:0] pos);
        if (w) begin
            case (pos)
                2'd0:    return SYM_P;
                2'd1:    return SYM_A;
                default: return SYM_5;
            endcase
        end else if (l) begin
            case (pos)
                2'd0:    return SYM_L;
                2'd1:    return SYM_0;
                2'd2:    return SYM_5;
                default: return SYM_E;
            endcase
        end else if (r) begin
            case (pos)
                2'd0:    return SYM_r;
                2'd1:    return SYM_o;
                default: return SYM_L;
            endcase
        end
        return SYM_BLANK;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational symbol-code to active-low cathode pattern decoder.
module seg_decode
    import dice_display_pkg::*;
(
    input  sym_e       i_sym,
    output logic [6:0] o_seg
);

    // Table lookup; unused codes render blank
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_sym)
            SYM_0:     o_seg = SEG_0;
            SYM_1:     o_seg = SEG_1;
            SYM_2:     o_seg = SEG_2;
            SYM_3:     o_seg = SEG_3;
            SYM_4:     o_seg = SEG_4;
            SYM_5:     o_seg = SEG_5;
            SYM_6:     o_seg = SEG_6;
            SYM_DASH:  o_seg = SEG_DASH;
            SYM_P:     o_seg = SEG_P;
            SYM_A:     o_seg = SEG_A;
            SYM_L:     o_seg = SEG_L;
            SYM_E:     o_seg = SEG_E;
            SYM_r:     o_seg = SEG_r;
            SYM_o:     o_seg = SEG_o;
            default:   o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/dice_seg_display.sv
// 8-digit multiplexed seven-segment driver for the dice game: dice on the
// two rightmost digits, a blinking status word on the four leftmost digits.
// Game inputs are snapshotted once per scan frame so a frame never tears.
module dice_seg_display
    import dice_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Win,
    input  logic       Lose,
    input  logic       Roll,
    input  logic [2:0] Diceout1,
    input  logic [2:0] Diceout2,
    output logic [7:0] Anode,
    output logic [6:0] Cathode
);

    localparam int RW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [RW-1:0] r_refresh_cnt;
    logic [2:0]    r_digit_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic          r_sh_win, r_sh_lose, r_sh_roll;
    logic [2:0]    r_sh_dice1, r_sh_dice2;

    logic          w_tick;
    logic          w_frame_end;
    logic          w_wl;
    logic          w_blink_wrap;
    logic [2:0]    w_pos;
    sym_e          w_sym;
    logic [6:0]    w_seg;

    assign w_tick       = (r_refresh_cnt == RW'(REFRESH_DIV - 1));
    assign w_frame_end  = w_tick && (r_digit_idx == DIG_LAST);
    assign w_wl         = r_sh_win | r_sh_lose;
    assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_FRAMES - 1));
    assign w_pos        = DIG_LAST - r_digit_idx;

    // Per-digit dwell counter and digit scan index
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= '0;
        end else if (w_tick) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= r_digit_idx + 3'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + RW'(1);
        end
    end

    // Snapshot the game state at the frame boundary only
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_sh_win   <= 1'b0;
            r_sh_lose  <= 1'b0;
            r_sh_roll  <= 1'b0;
            r_sh_dice1 <= '0;
            r_sh_dice2 <= '0;
        end else if (w_frame_end) begin
            r_sh_win   <= Win;
            r_sh_lose  <= Lose;
            r_sh_roll  <= Roll;
            r_sh_dice1 <= Diceout1;
            r_sh_dice2 <= Diceout2;
        end
    end

    // Blink phase: counts frames while Win/Lose is shown, parked visible otherwise
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (!w_wl) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_frame_end) begin
            if (w_blink_wrap) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    // Pick the symbol for the digit currently being scanned
    always_comb begin
        w_sym = SYM_BLANK;
        case (r_digit_idx)
            DIG_DICE2: w_sym = die_sym(r_sh_dice2);
            DIG_DICE1: w_sym = die_sym(r_sh_dice1);
            3'd2, 3'd3: w_sym = SYM_BLANK;
            default: begin
                if (w_wl && !r_blink_on)
                    w_sym = SYM_BLANK;
                else
                    w_sym = status_sym(r_sh_win, r_sh_lose, r_sh_roll, w_pos[1:0]);
            end
        endcase
    end

    seg_decode u_seg_decode (
        .i_sym (w_sym),
        .o_seg (w_seg)
    );

    // Register anode and cathode together so the digit switch is glitch-aligned
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            Anode   <= 8'hFF;
            Cathode <= SEG_BLANK;
        end else begin
            Anode   <= ~(8'b1 << r_digit_idx);
            Cathode <= w_seg;
        end
    end

endmodule

// File: tb/tb_dice_seg_display.sv
// Self-checking bench for dice_seg_display with a short refresh and blink.
// The reference model works at frame level: one snapshot per 32-edge frame,
// blink phase from the frame's position within a run of Win/Lose frames.
module tb_dice_seg_display;

    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FR = 8 * RD;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       Win = 1'b0, Lose = 1'b0, Roll = 1'b0;
    logic [2:0] Diceout1 = '0, Diceout2 = '0;
    logic [7:0] Anode;
    logic [6:0] Cathode;

    dice_seg_display #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .Win      (Win),
        .Lose     (Lose),
        .Roll     (Roll),
        .Diceout1 (Diceout1),
        .Diceout2 (Diceout2),
        .Anode    (Anode),
        .Cathode  (Cathode)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       w, l, r;
        logic [2:0] d1, d2;
    } shadow_t;

    typedef struct {
        logic             w, l, r;
        logic [2:0]       d1, d2;
        logic [7:0][6:0]  exp;   // [digit] expected cathode
    } vec_t;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      n        = 0;    // edges since reset release
    shadow_t m_sh;
    int      m_run    = 0;    // frame position within current Win/Lose run

    function automatic logic [6:0] die_seg(input logic [2:0] v);
        case (v)
            3'd0: return 7'h3F;
            3'd1: return 7'h79;
            3'd2: return 7'h24;
            3'd3: return 7'h30;
            3'd4: return 7'h19;
            3'd5: return 7'h12;
            3'd6: return 7'h02;
            default: return 7'h7F;
        endcase
    endfunction

    // k = 0 is the leftmost status digit
    function automatic logic [6:0] word_seg(input shadow_t s, input int k);
        if (s.w) begin
            case (k) 0: return 7'h0C; 1: return 7'h08; default: return 7'h12; endcase
        end else if (s.l) begin
            case (k) 0: return 7'h47; 1: return 7'h40; 2: return 7'h12; default: return 7'h06; endcase
        end else if (s.r) begin
            case (k) 0: return 7'h2F; 1: return 7'h23; default: return 7'h47; endcase
        end
        return 7'h7F;
    endfunction

    function automatic logic [6:0] model_cath(input int d);
        bit vis;
        vis = ((m_run / BF) % 2) == 0;
        if (d == 0) return die_seg(m_sh.d2);
        if (d == 1) return die_seg(m_sh.d1);
        if (d < 4)  return 7'h7F;
        if ((m_sh.w || m_sh.l) && !vis) return 7'h7F;
        return word_seg(m_sh, 7 - d);
    endfunction

    function automatic vec_t mkv(input logic w, l, r, input logic [2:0] d1, d2,
                                 input logic [7:0][6:0] e);
        vec_t v;
        v.w = w; v.l = l; v.r = r; v.d1 = d1; v.d2 = d2; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%h expected=%h", name, n, got, exp);
        end
    endtask

    task automatic set_in(input logic w, l, r, input logic [2:0] d1, d2);
        Win = w; Lose = l; Roll = r; Diceout1 = d1; Diceout2 = d2;
    endtask

    // One clock edge: compare against the model, then apply frame-boundary snapshot
    task automatic step();
        int d;
        logic [7:0] ea;
        shadow_t ns;
        @(posedge CLK);
        #1;
        n++;
        d  = ((n - 1) / RD) % 8;
        ea = ~(8'b1 << d);
        check("model_anode", Anode, ea);
        check("model_cathode", {1'b0, Cathode}, {1'b0, model_cath(d)});
        if (n % FR == 0) begin
            ns.w = Win; ns.l = Lose; ns.r = Roll; ns.d1 = Diceout1; ns.d2 = Diceout2;
            if (ns.w || ns.l)
                m_run = (m_sh.w || m_sh.l) ? m_run + 1 : 0;
            m_sh = ns;
        end
    endtask

    // Called just after an edge; checks the asynchronous effect before the next edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_async_anode", Anode, 8'hFF);
        check("rst_async_cathode", {1'b0, Cathode}, 8'h7F);
        @(posedge CLK);
        #1;
        check("rst_hold_anode", Anode, 8'hFF);
        check("rst_hold_cathode", {1'b0, Cathode}, 8'h7F);
        reset = 1'b0;
        n = 0;
        m_sh = '{default: '0};
        m_run = 0;
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    vec_t vt[6];

    initial begin
        // Steady-state frames in the visible phase, digits listed 7 down to 0
        vt[0] = mkv(0, 0, 1, 3'd3, 3'd5, {7'h2F, 7'h23, 7'h47, 7'h47, 7'h7F, 7'h7F, 7'h30, 7'h12});
        vt[1] = mkv(1, 0, 0, 3'd3, 3'd4, {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h7F, 7'h30, 7'h19});
        vt[2] = mkv(1, 1, 0, 3'd1, 3'd2, {7'h0C, 7'h08, 7'h12, 7'h12, 7'h7F, 7'h7F, 7'h79, 7'h24});
        vt[3] = mkv(0, 1, 0, 3'd6, 3'd0, {7'h47, 7'h40, 7'h12, 7'h06, 7'h7F, 7'h7F, 7'h02, 7'h3F});
        vt[4] = mkv(0, 0, 0, 3'd0, 3'd7, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h7F});
        vt[5] = mkv(0, 1, 1, 3'd2, 3'd6, {7'h47, 7'h40, 7'h12, 7'h06, 7'h7F, 7'h7F, 7'h24, 7'h02});

        m_sh = '{default: '0};
        #2;

        // Reset mid-digit-3, then first edge and full anode walk with wrap
        do_reset();
        repeat (13) step();
        do_reset();
        step();
        check("first_anode", Anode, 8'hFE);
        check("first_cathode", {1'b0, Cathode}, 8'h3F);
        run_to(40);

        // Mid-frame input change stays invisible until the next frame
        set_in(0, 0, 0, 3'd0, 3'd0);
        do_reset();
        run_to(10);
        set_in(0, 0, 1, 3'd3, 3'd5);
        run_to(29);
        check("midframe_digit7", {1'b0, Cathode}, 8'h7F);
        run_to(33);
        check("newframe_digit0", {1'b0, Cathode}, 8'h12);
        run_to(61);
        check("newframe_digit7", {1'b0, Cathode}, 8'h2F);

        // Table of steady-state words
        for (int i = 0; i < 6; i++) begin
            do_reset();
            set_in(vt[i].w, vt[i].l, vt[i].r, vt[i].d1, vt[i].d2);
            run_to(FR);
            for (int e = 0; e < FR; e++) begin
                step();
                if (e % RD == 0)
                    check("table_cathode", {1'b0, Cathode}, {1'b0, vt[i].exp[e / RD]});
            end
        end

        // Win blink cadence, then Lose continuing the blink, reset in blink-off
        do_reset();
        set_in(1, 0, 0, 3'd3, 3'd4);
        run_to(FR * 1 + 29);
        check("win_on_digit7", {1'b0, Cathode}, 8'h0C);
        run_to(FR * 3 + 1);
        check("win_off_digit0", {1'b0, Cathode}, 8'h19);
        run_to(FR * 3 + 5);
        check("win_off_digit1", {1'b0, Cathode}, 8'h30);
        run_to(FR * 3 + 29);
        check("win_off_digit7", {1'b0, Cathode}, 8'h7F);
        run_to(FR * 5 + 29);
        check("win_on_again_digit7", {1'b0, Cathode}, 8'h0C);
        set_in(0, 1, 0, 3'd3, 3'd4);
        run_to(FR * 6 + 29);
        check("lose_on_digit7", {1'b0, Cathode}, 8'h47);
        run_to(FR * 7 + 29);
        check("lose_off_digit7", {1'b0, Cathode}, 8'h7F);
        set_in(0, 0, 0, 3'd0, 3'd0);
        do_reset();
        run_to(1);
        check("post_rst_digit0", {1'b0, Cathode}, 8'h3F);
        run_to(5);
        check("post_rst_digit1", {1'b0, Cathode}, 8'h3F);
        run_to(29);
        check("post_rst_digit7", {1'b0, Cathode}, 8'h7F);

        // Win/Lose drop while blanked -> Roll word reappears immediately
        do_reset();
        set_in(0, 1, 1, 3'd0, 3'd7);
        run_to(FR * 3 + 10);
        set_in(0, 0, 1, 3'd0, 3'd7);
        run_to(FR * 4 + 1);
        check("drop_digit0", {1'b0, Cathode}, 8'h7F);
        run_to(FR * 4 + 5);
        check("drop_digit1", {1'b0, Cathode}, 8'h3F);
        run_to(FR * 4 + 29);
        check("drop_digit7", {1'b0, Cathode}, 8'h2F);
        run_to(FR * 5 + 29);

        // Random input traffic against the frame-level model
        do_reset();
        for (int c = 0; c < 60 * FR; c++) begin
            if ($urandom_range(0, 47) == 0)
                set_in(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
